// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Pulls a program image out of a byte stream and writes it into instruction
// memory one 32-bit word at a time. When the whole image has been written, the
// loader releases the core. The stream is a little-endian 4-byte word count N
// followed by N little-endian words. Word k of the image is written to
// BASE_ADDR + 4*k.
//
// Parameters
//   BASE_ADDR      byte address of the first instruction word
//   DEPTH_WORDS    largest accepted word count
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   byte_valid_i     upstream byte valid
//   byte_data_i      upstream byte
//   byte_ready_o     loader can take a byte this cycle
//   mem_req_o        instruction-memory write request
//   mem_gnt_i        memory accepts the pending write this cycle
//   mem_addr_o       write byte address
//   mem_wdata_o      write data
//   mem_be_o         byte enables, always all four lanes
//   fetch_enable_o   core may start fetching at BASE_ADDR
//   done_o           image loaded completely
//   error_o          header rejected, load aborted
// -----------------------------------------------------------------------------
module boot_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        fetch_enable_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    state_t      r_state;
    logic [1:0]  r_byteCnt;
    logic [31:0] r_count;
    logic [31:0] r_idx;
    logic [31:0] r_word;
    logic [31:0] r_addr;
    logic        r_memReq;
    logic        r_byteReady;
    logic        r_fetch;
    logic        r_done;
    logic        r_error;

    logic        w_accept;
    logic        w_lastByte;
    logic [31:0] w_hdrWord;
    logic [31:0] w_dataWord;
    logic [31:0] w_idxNext;

    // Ready comes from a register, so a transfer depends only on
    // the incoming valid and that registered ready.
    assign w_accept   = byte_valid_i & r_byteReady;
    assign w_lastByte = (r_byteCnt == 2'd3);

    // Bytes shift in from the top. After four bytes, the first byte received
    // has reached bits 7:0, which gives the little-endian order.
    assign w_hdrWord  = {byte_data_i, r_count[31:8]};
    assign w_dataWord = {byte_data_i, r_word[31:8]};
    assign w_idxNext  = r_idx + 32'd1;

    assign byte_ready_o   = r_byteReady;
    assign mem_req_o      = r_memReq;
    assign mem_addr_o     = r_addr;
    assign mem_wdata_o    = r_word;
    assign mem_be_o       = 4'b1111;
    assign fetch_enable_o = r_fetch;
    assign done_o         = r_done;
    assign error_o        = r_error;

    // Loader FSM. All outputs are registers that change together with the
    // state.
    // - ready drops on the same edge that enters WRITE/DONE/ERR, and rises
    //   again on the grant edge. The next byte can therefore transfer no
    //   earlier than the cycle after the grant.
    // - The byte counter is a 2-bit value. It wraps to 0 by itself after
    //   every field.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= HDR;
            r_byteCnt   <= 2'd0;
            r_count     <= 32'd0;
            r_idx       <= 32'd0;
            r_word      <= 32'd0;
            r_addr      <= 32'd0;
            r_memReq    <= 1'b0;
            r_byteReady <= 1'b0;
            r_fetch     <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                HDR: begin
                    r_byteReady <= 1'b1;
                    if (w_accept) begin
                        r_count   <= w_hdrWord;
                        r_byteCnt <= r_byteCnt + 2'd1;
                        if (w_lastByte) begin
                            if ((w_hdrWord == 32'd0) || (w_hdrWord > DEPTH_LIMIT)) begin
                                r_state     <= ERR;
                                r_byteReady <= 1'b0;
                                r_error     <= 1'b1;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_word    <= w_dataWord;
                        r_byteCnt <= r_byteCnt + 2'd1;
                        if (w_lastByte) begin
                            r_state     <= WRITE;
                            r_byteReady <= 1'b0;
                            r_memReq    <= 1'b1;
                            r_addr      <= BASE_ADDR + (r_idx << 2);
                        end
                    end
                end
                WRITE: begin
                    if (mem_gnt_i) begin
                        r_memReq <= 1'b0;
                        r_idx    <= w_idxNext;
                        if (w_idxNext == r_count) begin
                            r_state <= DONE;
                            r_fetch <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= DATA;
                            r_byteReady <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state     <= HDR;
                    r_byteReady <= 1'b0;
                    r_memReq    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: maximum loadable program size in 32-bit words.
REQ-003 SHALL have port clk_i  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port byte_valid_i  input  1: the upstream byte stream holds a valid byte.
REQ-006 SHALL have port byte_data_i  input  8: the stream byte.
REQ-007 SHALL have port byte_ready_o  output  1: the loader accepts a byte; a transfer occurs on a rising edge with valid and ready both high.
REQ-008 SHALL have port mem_req_o  output  1: instruction-memory write request.
REQ-009 SHALL have port mem_gnt_i  input  1: the memory accepts the write in the current cycle.
REQ-010 SHALL have port mem_addr_o  output  32: write byte address.
REQ-011 SHALL have port mem_wdata_o  output  32: write data.
REQ-012 SHALL have port mem_be_o  output  4: byte enables, constant 4'b1111.
REQ-013 SHALL have port fetch_enable_o  output  1: releases the core to fetch at BASE_ADDR.
REQ-014 SHALL have port done_o  output  1: load completed successfully.
REQ-015 SHALL have port error_o  output  1: load aborted on a bad header.

Function
REQ-016 Stream format SHALL be a 4-byte header N (word count), then N words; every field is little-endian, and the first byte received maps to bits 7:0.
REQ-017 States SHALL be HDR, DATA, WRITE, DONE and ERR; the reset state SHALL be HDR.
REQ-018 byte_ready_o SHALL be high only in HDR and DATA, and SHALL be driven from state registers only, with no combinational path from byte_valid_i.
REQ-019 HDR SHALL assemble 4 accepted bytes into N; on the 4th byte, if N==0 or N>DEPTH_WORDS the next state SHALL be ERR, otherwise DATA.
REQ-020 DATA SHALL assemble 4 accepted bytes into a word register; on the 4th byte the next state SHALL be WRITE.
REQ-021 In WRITE, mem_req_o SHALL be high, with mem_addr_o = BASE_ADDR + 4*idx and mem_wdata_o = the assembled word, and all three SHALL stay stable until the cycle mem_gnt_i is high.
REQ-022 On a grant, idx SHALL increment; if idx+1==N the next state SHALL be DONE, otherwise DATA.
REQ-023 mem_req_o SHALL be low in every state except WRITE.
REQ-024 mem_gnt_i outside WRITE SHALL be ignored.
REQ-025 Latency: mem_req_o SHALL rise the cycle after the 4th data byte is accepted, and the first byte of the next word SHALL be accepted no earlier than the cycle after the grant.
REQ-026 DONE SHALL drive fetch_enable_o=1 and done_o=1, registered, held until reset, and SHALL ignore all stream traffic.
REQ-027 ERR SHALL drive error_o=1, with fetch_enable_o=0 and done_o=0, held until reset.
REQ-028 The byte counter (2 bits) SHALL wrap 3->0 per field; idx and N SHALL be 32 bits, with comparisons unsigned.
REQ-029 A byte_valid_i gap mid-word SHALL stall assembly without loss or duplication.

Reset
REQ-030 Asserting rst_i SHALL immediately clear all outputs to 0 (mem_be_o excepted, which stays 4'b1111), set state to HDR, and clear idx, N, the byte counter and the word register.
REQ-031 Reset mid-load, including during WRITE with the grant outstanding, SHALL abort the load: mem_req_o SHALL drop asynchronously and no partial state SHALL persist after release.
REQ-032 On the first edge after rst_i deasserts, byte_ready_o SHALL be 1.

Verification
REQ-033 Stream 02 00 00 00, 13 05 00 00, 93 05 10 00 with mem_gnt_i tied high -> writes (0x0, 0x00000513), then (0x4, 0x00100593); fetch_enable_o=1 and done_o=1 the cycle after the 2nd grant.
REQ-034 Same stream with mem_gnt_i delayed 3 cycles per request -> mem_req_o, mem_addr_o and mem_wdata_o stable for 4 cycles per write, byte_ready_o=0 throughout, and identical final memory.
REQ-035 Header 00 00 00 00 -> error_o=1, no mem_req_o ever, fetch_enable_o stays 0.
REQ-036 With DEPTH_WORDS=4, header 05 00 00 00 -> error_o=1 and no writes.
REQ-037 Random byte_valid_i gaps over a 16-word fibonacci image -> memory contents match the image exactly, with no duplicated or dropped bytes.
REQ-038 rst_i pulsed during the 2nd WRITE, then a 1-word stream -> the single write lands at BASE_ADDR and done_o=1.
